// File: rtl/sha_pkg.sv
// Shared types and constants for the SHA-256 nonce scheduler slice.
// Optional feature macro used by the scheduler: SCHED_BEST_TRACK_EN.
package sha_pkg;

  // Scheduler sequencing states, one per step of a single nonce trial.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PATCH,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_FETCH_ADDR,
    ST_FETCH_DATA,
    ST_CHECK
  } sched_state_t;

  // Number of 32-bit words the core writes at output_addr (h0..h7).
  localparam int SHA_HASH_WORDS = 8;

  // Watchdog budget for one core run when the instantiation does not override it.
  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

  // True while the core owns the memory port.
  function automatic logic core_owns_port(sched_state_t s);
    return (s == ST_WAIT_BUSY) || (s == ST_WAIT_DONE);
  endfunction

endpackage

// File: rtl/sha256_nonce_scheduler_if.sv
// Core handshake plus shared memory port seen by the nonce scheduler.
// master: the scheduler; slave: the SHA core / memory pair.
interface sha256_nonce_scheduler_if;

  logic        core_start;
  logic        core_done;
  logic [15:0] core_mem_addr;
  logic        core_mem_we;
  logic [31:0] core_mem_write_data;

  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    output core_start, mem_we, mem_addr, mem_write_data,
    input  core_done, core_mem_addr, core_mem_we, core_mem_write_data, mem_read_data
  );

  modport slave (
    input  core_start, mem_we, mem_addr, mem_write_data,
    output core_done, core_mem_addr, core_mem_we, core_mem_write_data, mem_read_data
  );

endinterface

// File: rtl/sha_mem_mux.sv
// Combinational owner select for the single memory port: the core drives it
// while hashing, the scheduler drives it otherwise.
module sha_mem_mux (
  input  logic        core_owns,
  input  logic        sched_we,
  input  logic [15:0] sched_addr,
  input  logic [31:0] sched_write_data,
  input  logic        core_we,
  input  logic [15:0] core_addr,
  input  logic [31:0] core_write_data,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data
);

  assign mem_we         = core_owns ? core_we         : sched_we;
  assign mem_addr       = core_owns ? core_addr       : sched_addr;
  assign mem_write_data = core_owns ? core_write_data : sched_write_data;

endmodule

// File: rtl/sha256_nonce_scheduler.sv
// Nonce scan sequencer: patches each nonce into the message buffer, runs the
// SHA core, reads back h0 and compares it against the target.
// Optional feature macro: SCHED_BEST_TRACK_EN (scan the full range and track
// the smallest h0 seen plus its nonce).
module sha256_nonce_scheduler
  import sha_pkg::*;
#(
  parameter int NUM_OF_WORDS   = 20,
  parameter int NONCE_WORD     = 19,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] nonce_base,
  input  logic [15:0] num_nonces,
  input  logic [31:0] target,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  output logic        done,
  output logic        found,
  output logic [31:0] found_nonce,
  output logic        timeout,
`ifdef SCHED_BEST_TRACK_EN
  output logic [31:0] best_h0,
  output logic [31:0] best_nonce,
`endif
  output logic        mem_clk,
  sha256_nonce_scheduler_if.master bus
);

  // An out-of-range nonce offset is clamped to the last message word.
  localparam int NONCE_OFFSET = (NONCE_WORD < NUM_OF_WORDS) ? NONCE_WORD : NUM_OF_WORDS - 1;

  sched_state_t state, next_state;

  logic [31:0] cur_nonce;
  logic [15:0] remaining;
  logic [31:0] h0;
  logic [31:0] wd_cnt;

  logic        core_owns;
  logic        wd_expired;
  logic        hit;
  logic        last_nonce;
  logic [15:0] patch_addr;

  logic        sched_we;
  logic [15:0] sched_addr;
  logic [31:0] sched_write_data;
  logic        core_start_c;

  assign mem_clk    = clk;
  assign core_owns  = core_owns_port(state);
  assign wd_expired = core_owns && (wd_cnt >= 32'(TIMEOUT_CYCLES - 1));
  assign hit        = (h0 < target);
  assign last_nonce = (remaining == 16'd1);
  assign patch_addr = message_addr + 16'(NONCE_OFFSET);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next-state decode; the watchdog takes priority over a late core_done.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:       if (start && (num_nonces != 16'd0)) next_state = ST_PATCH;
      ST_PATCH:      next_state = ST_LAUNCH;
      ST_LAUNCH:     next_state = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (wd_expired)          next_state = ST_IDLE;
        else if (!bus.core_done) next_state = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (wd_expired)         next_state = ST_IDLE;
        else if (bus.core_done) next_state = ST_FETCH_ADDR;
      end
      ST_FETCH_ADDR: next_state = ST_FETCH_DATA;
      ST_FETCH_DATA: next_state = ST_CHECK;
      ST_CHECK: begin
`ifdef SCHED_BEST_TRACK_EN
        next_state = last_nonce ? ST_IDLE : ST_PATCH;
`else
        next_state = (hit || last_nonce) ? ST_IDLE : ST_PATCH;
`endif
      end
      default:       next_state = ST_IDLE;
    endcase
  end

  // Scheduler-side memory drive, core start pulse and done flag.
  always_comb begin
    sched_we         = 1'b0;
    sched_addr       = 16'd0;
    sched_write_data = 32'd0;
    core_start_c     = 1'b0;
    done             = 1'b0;
    case (state)
      ST_IDLE:       done = 1'b1;
      ST_PATCH: begin
        sched_we         = 1'b1;
        sched_addr       = patch_addr;
        sched_write_data = cur_nonce;
      end
      ST_LAUNCH:     core_start_c = 1'b1;
      ST_FETCH_ADDR: sched_addr   = output_addr;
      default:       ;
    endcase
  end

  assign bus.core_start = core_start_c;

  sha_mem_mux u_mem_mux (
    .core_owns        (core_owns),
    .sched_we         (sched_we),
    .sched_addr       (sched_addr),
    .sched_write_data (sched_write_data),
    .core_we          (bus.core_mem_we),
    .core_addr        (bus.core_mem_addr),
    .core_write_data  (bus.core_mem_write_data),
    .mem_we           (bus.mem_we),
    .mem_addr         (bus.mem_addr),
    .mem_write_data   (bus.mem_write_data)
  );

  // Watchdog: zero on entry to LAUNCH, counts every cycle of the core run.
  always_ff @(posedge clk) begin
    if (!reset_n)                                 wd_cnt <= 32'd0;
    else if (next_state == ST_LAUNCH)             wd_cnt <= 32'd0;
    else if (core_owns || (state == ST_LAUNCH))   wd_cnt <= wd_cnt + 32'd1;
  end

  // Scan datapath: nonce/range bookkeeping, h0 capture and result flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_nonce   <= 32'd0;
      remaining   <= 16'd0;
      h0          <= 32'd0;
      found       <= 1'b0;
      found_nonce <= 32'd0;
      timeout     <= 1'b0;
`ifdef SCHED_BEST_TRACK_EN
      best_h0     <= 32'hFFFF_FFFF;
      best_nonce  <= 32'd0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cur_nonce <= nonce_base;
            remaining <= num_nonces;
            found     <= 1'b0;
            timeout   <= 1'b0;
`ifdef SCHED_BEST_TRACK_EN
            best_h0   <= 32'hFFFF_FFFF;
`endif
          end
        end
        ST_WAIT_BUSY, ST_WAIT_DONE: begin
          if (wd_expired) timeout <= 1'b1;
        end
        ST_FETCH_DATA: h0 <= bus.mem_read_data;
        ST_CHECK: begin
`ifdef SCHED_BEST_TRACK_EN
          if (hit && !found) begin
            found       <= 1'b1;
            found_nonce <= cur_nonce;
          end
          if (h0 < best_h0) begin
            best_h0    <= h0;
            best_nonce <= cur_nonce;
          end
          remaining <= remaining - 16'd1;
          cur_nonce <= cur_nonce + 32'd1;
`else
          if (hit) begin
            found       <= 1'b1;
            found_nonce <= cur_nonce;
          end else begin
            remaining <= remaining - 16'd1;
            cur_nonce <= cur_nonce + 32'd1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_nonce_scheduler.sv
// Self-checking bench for sha256_nonce_scheduler with a behavioural SHA core
// and memory; a scoreboard queue holds per-scan expectations and a monitor
// compares them when done rises. Honours SCHED_BEST_TRACK_EN if defined.
module tb_sha256_nonce_scheduler;
  import sha_pkg::*;

  localparam int T  = 32;
  localparam int NW = 19;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] nonce_base;
  logic [15:0] num_nonces;
  logic [31:0] target;
  logic [15:0] message_addr;
  logic [15:0] output_addr;
  logic        done;
  logic        found;
  logic [31:0] found_nonce;
  logic        timeout;
  logic        mem_clk;
`ifdef SCHED_BEST_TRACK_EN
  logic [31:0] best_h0;
  logic [31:0] best_nonce;
`endif

  sha256_nonce_scheduler_if bus();

  sha256_nonce_scheduler #(
    .NUM_OF_WORDS   (20),
    .NONCE_WORD     (NW),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .nonce_base   (nonce_base),
    .num_nonces   (num_nonces),
    .target       (target),
    .message_addr (message_addr),
    .output_addr  (output_addr),
    .done         (done),
    .found        (found),
    .found_nonce  (found_nonce),
    .timeout      (timeout),
`ifdef SCHED_BEST_TRACK_EN
    .best_h0      (best_h0),
    .best_nonce   (best_nonce),
`endif
    .mem_clk      (mem_clk),
    .bus          (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        found;
    logic [31:0] fnonce;
    logic        tmo;
    int          launches;
    logic        chk_best;
    logic [31:0] best_h0;
    logic [31:0] best_nonce;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] patch_q[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mon_launches = 0;
  int          mon_writes = 0;
  int          launch_cyc = 0;
  int          hash_sel = 0;
  bit          core_stuck = 1'b0;
  logic [15:0] cur_msg = 16'd0;
  logic [31:0] model_best_nonce = 32'd0;
  logic [31:0] mem [0:65535];

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural hash: a fixed mixer, or a single planted hit at nonce 2.
  function automatic logic [31:0] ref_hash(logic [31:0] n);
    logic [31:0] x;
    if (hash_sel == 1) return (n == 32'd2) ? 32'h0000_0010 : 32'hFFFF_FF00;
    x = n ^ 32'hA5A5_1234;
    x = x * 32'h9E37_79B1;
    x = x ^ (x >> 15);
    x = x * 32'h85EB_CA6B;
    x = x ^ (x >> 13);
    return x;
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Memory: samples the port at the edge, applies it just after, read data
  // therefore valid the cycle after the address.
  initial begin
    logic [15:0] a;
    logic        we;
    logic [31:0] d;
    for (int i = 0; i < 65536; i++) mem[i] = 32'd0;
    bus.mem_read_data = 32'd0;
    forever begin
      @(posedge clk);
      a  = bus.mem_addr;
      we = bus.mem_we;
      d  = bus.mem_write_data;
      #1;
      if (we === 1'b1) mem[a] = d;
      bus.mem_read_data = mem[a];
    end
  end

  // SHA core model: drops done, hashes the patched nonce, writes h0 through
  // its own memory port, raises done. Stuck mode holds done low.
  initial begin
    int          lat;
    logic [31:0] h;
    bus.core_done           = 1'b1;
    bus.core_mem_we         = 1'b0;
    bus.core_mem_addr       = 16'd0;
    bus.core_mem_write_data = 32'd0;
    forever begin
      @(negedge clk);
      if (bus.core_start === 1'b1) begin
        @(negedge clk);
        bus.core_done = 1'b0;
        if (core_stuck) begin
          while (core_stuck) @(negedge clk);
          bus.core_done = 1'b1;
        end else begin
          lat = $urandom_range(1, 4);
          repeat (lat) @(negedge clk);
          h = ref_hash(mem[16'(cur_msg + 16'(NW))]);
          bus.core_mem_addr       = output_addr;
          bus.core_mem_write_data = h;
          bus.core_mem_we         = 1'b1;
          @(negedge clk);
          bus.core_mem_we = 1'b0;
          bus.core_done   = 1'b1;
        end
      end
    end
  end

  // Monitor: counts launches, checks patched nonces, scores each finished scan.
  initial begin
    logic prev_done;
    exp_t e;
    int   dl;
    prev_done = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.core_start === 1'b1) begin
        mon_launches++;
        launch_cyc = cyc;
      end
      if (bus.mem_we === 1'b1 && bus.core_mem_we !== 1'b1) begin
        mon_writes++;
        if (bus.mem_addr == 16'(cur_msg + 16'(NW))) begin
          if (patch_q.size() == 0) checkOutput("patch_unexpected", 32'(patch_q.size()), 32'd1);
          else checkOutput("patch_nonce", bus.mem_write_data, patch_q.pop_front());
        end
      end
      if (done === 1'b1 && prev_done === 1'b0) begin
        if (exp_q.size() == 0) begin
          checkOutput("scan_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("found", 32'(found), 32'(e.found));
          checkOutput("timeout", 32'(timeout), 32'(e.tmo));
          checkOutput("launches", 32'(mon_launches), 32'(e.launches));
          if (e.found) checkOutput("found_nonce", found_nonce, e.fnonce);
          if (e.tmo) begin
            dl = cyc - launch_cyc;
            checkOutput("timeout_latency_ok", 32'(dl >= T - 2 && dl <= T), 32'd1);
          end
`ifdef SCHED_BEST_TRACK_EN
          if (e.chk_best) begin
            checkOutput("best_h0", best_h0, e.best_h0);
            checkOutput("best_nonce", best_nonce, e.best_nonce);
          end
`endif
        end
        mon_launches = 0;
      end
      prev_done = done;
    end
  end

  task automatic doReset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_best_nonce = 32'd0;
    @(negedge clk);
  endtask

  // Builds the expected scan outcome from the rules, then launches the scan.
  task automatic applyStimulus(logic [31:0] base, logic [15:0] num, logic [31:0] tgt,
                               logic [15:0] msg, logic [15:0] outa, bit expect_tmo);
    exp_t        e;
    logic [31:0] n;
    logic [31:0] h;
    logic [31:0] bh;
    int          w0;
    int          budget;
    e.found = 1'b0; e.fnonce = 32'd0; e.tmo = expect_tmo; e.launches = 0;
    e.chk_best = !expect_tmo;
    bh = 32'hFFFF_FFFF;
    for (int i = 0; i < int'(num); i++) begin
      n = base + 32'(i);
      patch_q.push_back(n);
      e.launches++;
      if (expect_tmo) break;
      h = ref_hash(n);
      if (h < bh) begin
        bh = h;
        model_best_nonce = n;
      end
      if (h < tgt && !e.found) begin
        e.found  = 1'b1;
        e.fnonce = n;
`ifndef SCHED_BEST_TRACK_EN
        break;
`endif
      end
    end
    e.best_h0    = bh;
    e.best_nonce = model_best_nonce;
    if (num != 16'd0) exp_q.push_back(e);
    w0 = mon_writes;
    nonce_base = base; num_nonces = num; target = tgt;
    message_addr = msg; output_addr = outa; cur_msg = msg;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (num == 16'd0) begin
      repeat (4) @(negedge clk);
      checkOutput("zero_done", 32'(done), 32'd1);
      checkOutput("zero_writes", 32'(mon_writes - w0), 32'd0);
      checkOutput("zero_found", 32'(found), 32'd0);
    end else begin
      budget = 0;
      while (exp_q.size() != 0 && budget < 3000) begin
        @(negedge clk);
        budget++;
      end
      @(negedge clk);
      checkOutput("scan_finished", 32'(exp_q.size()), 32'd0);
      if (exp_q.size() != 0) begin
        exp_q.delete();
        patch_q.delete();
        doReset();
      end
    end
  endtask

  // Aborts a scan with reset while the core is hashing.
  task automatic resetMidScan();
    exp_t e;
    e.found = 1'b0; e.fnonce = 32'd0; e.tmo = 1'b0; e.launches = 1;
    e.chk_best = 1'b0; e.best_h0 = 32'd0; e.best_nonce = 32'd0;
    core_stuck = 1'b1;
    patch_q.push_back(32'hABCD_0000);
    exp_q.push_back(e);
    nonce_base = 32'hABCD_0000; num_nonces = 16'd1; target = 32'hFFFF_FFFF;
    message_addr = 16'h0400; output_addr = 16'h0500; cur_msg = 16'h0400;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("busy_done_low", 32'(done), 32'd0);
    nonce_base = 32'h1111_0000; num_nonces = 16'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("busy_start_ignored", 32'(mon_launches), 32'd1);
    checkOutput("busy_still_waiting", 32'(done), 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_done", 32'(done), 32'd1);
    checkOutput("rst_mid_core_start", 32'(bus.core_start), 32'd0);
    checkOutput("rst_mid_found", 32'(found), 32'd0);
    checkOutput("rst_mid_mem_we", 32'(bus.mem_we), 32'd0);
    reset_n = 1'b1;
    model_best_nonce = 32'd0;
    core_stuck = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("rst_mid_scan_closed", 32'(exp_q.size()), 32'd0);
  endtask

  // Main sequence.
  initial begin
    logic [31:0] rb;
    logic [15:0] rn;
    logic [31:0] rt;
    logic [15:0] rm;
    reset_n = 1'b0; start = 1'b0;
    nonce_base = 32'd0; num_nonces = 16'd0; target = 32'd0;
    message_addr = 16'd0; output_addr = 16'd0;
    repeat (3) @(negedge clk);
    checkOutput("rst_done", 32'(done), 32'd1);
    checkOutput("rst_found", 32'(found), 32'd0);
    checkOutput("rst_found_nonce", found_nonce, 32'd0);
    checkOutput("rst_timeout", 32'(timeout), 32'd0);
    checkOutput("rst_core_start", 32'(bus.core_start), 32'd0);
    checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("rst_mem_wdata", bus.mem_write_data, 32'd0);
`ifdef SCHED_BEST_TRACK_EN
    checkOutput("rst_best_h0", best_h0, 32'hFFFF_FFFF);
    checkOutput("rst_best_nonce", best_nonce, 32'd0);
`endif
    reset_n = 1'b1;
    @(negedge clk);

    hash_sel = 0;
    applyStimulus(32'h1234_5678, 16'd1, 32'hFFFF_FFFF, 16'h0000, 16'h0100, 1'b0);
    checkOutput("t1_mem_nonce", mem[16'h0013], 32'h1234_5678);
    checkOutput("t1_done", 32'(done), 32'd1);

    applyStimulus(32'hCAFE_0000, 16'd4, 32'd0, 16'h0000, 16'h0100, 1'b0);
    checkOutput("t2_mem_nonce", mem[16'h0013], 32'hCAFE_0003);

    applyStimulus(32'hFFFF_FFFF, 16'd2, 32'd0, 16'h0040, 16'h0200, 1'b0);
    checkOutput("t4_mem_nonce", mem[16'h0053], 32'h0000_0000);

    hash_sel = 1;
    applyStimulus(32'd0, 16'd8, 32'h0000_0100, 16'h0000, 16'h0100, 1'b0);
    hash_sel = 0;

    applyStimulus(32'h0BAD_0000, 16'd0, 32'hFFFF_FFFF, 16'h0000, 16'h0100, 1'b0);

    for (int k = 0; k < 8; k++) begin
      rb = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom;
      rn = 16'($urandom_range(1, 6));
      case ($urandom_range(0, 3))
        0:       rt = 32'd0;
        1:       rt = 32'hFFFF_FFFF;
        2:       rt = 32'($urandom_range(0, 32'h0800_0000));
        default: rt = $urandom;
      endcase
      rm = ($urandom_range(0, 3) == 0) ? 16'hFFF8 : 16'($urandom_range(0, 16'h7FFF));
      applyStimulus(rb, rn, rt, rm, rm ^ 16'h8000, 1'b0);
    end

    core_stuck = 1'b1;
    applyStimulus(32'h0000_0055, 16'd1, 32'hFFFF_FFFF, 16'h0010, 16'h0300, 1'b1);
    checkOutput("tmo_mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("tmo_idle", 32'(done), 32'd1);
    core_stuck = 1'b0;
    repeat (4) @(negedge clk);

    resetMidScan();

    applyStimulus(32'h0000_0777, 16'd0, 32'hFFFF_FFFF, 16'h0600, 16'h0700, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so a stalled run still reports.
  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL global_time_limit: got expired expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_nonce_scheduler.md
Name: sha256_nonce_scheduler

Overview:
Sequencer that drives one simplified SHA-256 core through a range of nonces.
- Per nonce: patches the nonce word into the message buffer in memory, launches the core, waits for completion, reads back hash word h0 and compares it against a target.
- Owns the single memory port and hands it to the core only while the core is hashing.
- Sits between the top-level miner control and the SHA core/memory pair.

Parameters:
NUM_OF_WORDS, 20, message length in words passed to the core; used only for range checks.
NONCE_WORD, 19, word offset of the nonce inside the message buffer (must be < NUM_OF_WORDS).
TIMEOUT_CYCLES, 4096, maximum cycles allowed for one core run.

Ports:
clk  in  1  clock; also forwarded as mem_clk
reset_n  in  1  synchronous active-low reset
start  in  1  begin a scan; sampled only in IDLE
nonce_base  in  32  first nonce
num_nonces  in  16  number of nonces to try
target  in  32  hit when h0 < target (unsigned)
message_addr  in  16  message buffer base address
output_addr  in  16  core hash output base address
done  out  1  high in IDLE
found  out  1  a hit occurred in the last scan
found_nonce  out  32  nonce of the hit
timeout  out  1  last scan aborted by watchdog
core_start  out  1  one-cycle start pulse to core
core_done  in  1  core done (high while core idle)
core_mem_addr  in  16  core memory address
core_mem_we  in  1  core write enable
core_mem_write_data  in  32  core write data
mem_clk  out  1  equal to clk
mem_we  out  1  memory write enable
mem_addr  out  16  memory address
mem_write_data  out  32  memory write data
mem_read_data  in  32  memory read data; valid the cycle after its address is presented

Behaviour:
- Reset (synchronous, reset_n low at posedge) forces:
  - state IDLE
  - core_start=0, mem_we=0, mem_addr=0, mem_write_data=0
  - found=0, found_nonce=0, timeout=0
  - internal nonce counter and remaining count cleared
- Reset mid-scan aborts immediately. Memory contents are not restored.
- States: IDLE, PATCH, LAUNCH, WAIT_BUSY, WAIT_DONE, FETCH_ADDR, FETCH_DATA, CHECK.
- IDLE: done=1.
  - start=1 latches nonce_base into cur_nonce and num_nonces into remaining; clears found and timeout.
  - If num_nonces=0, stay in IDLE: no memory access, found=0.
  - Otherwise go to PATCH.
  - start in any other state is ignored.
- PATCH (1 cycle): mem_we=1, mem_addr=message_addr+NONCE_WORD (16-bit wrap), mem_write_data=cur_nonce. Next: LAUNCH.
- LAUNCH (1 cycle): mem_we=0, core_start=1. Next: WAIT_BUSY.
- WAIT_BUSY: wait for core_done=0, then go to WAIT_DONE.
- WAIT_DONE: wait for core_done=1, then go to FETCH_ADDR.
- Memory mux: in WAIT_BUSY and WAIT_DONE, mem_addr/mem_we/mem_write_data are driven from the core_mem_* inputs. In all other states the scheduler drives them, and mem_we=0 except in PATCH.
- Watchdog: a cycle counter resets on entry to LAUNCH. If it reaches TIMEOUT_CYCLES while in WAIT_BUSY or WAIT_DONE: set timeout=1, return to IDLE, found unchanged.
- FETCH_ADDR: mem_addr=output_addr. Next: FETCH_DATA.
- FETCH_DATA: capture mem_read_data as h0. Next: CHECK.
- CHECK:
  - If h0 < target: found=1, found_nonce=cur_nonce, go to IDLE (first-hit exit).
  - Else decrement remaining and increment cur_nonce (32-bit wrap, 0xFFFFFFFF -> 0). If remaining is now 0, go to IDLE; otherwise go to PATCH.
  - target=0 therefore never hits.
- Per-nonce overhead excluding core time: 5 cycles (PATCH, LAUNCH, FETCH_ADDR, FETCH_DATA, CHECK) plus WAIT_BUSY entry.

Optional Feature:
SCHED_BEST_TRACK_EN.
- Defined:
  - No early exit; every nonce in the range is run.
  - Adds outputs best_h0[31:0] (reset 32'hFFFFFFFF, reloaded at scan start) and best_nonce[31:0] (reset 0).
  - Updated in CHECK when h0 < best_h0 (strict; ties keep the earlier nonce).
  - found/found_nonce report the first hit.
- Undefined: ports absent; first-hit exit as above.

Decomposition:
- Shared package sha_pkg: state enum type, SHA_HASH_WORDS=8, default TIMEOUT constant.
- One sub-module, sha_mem_mux: purely combinational select between scheduler and core memory signals. All sequencing stays in the top.

Test Plan:
1. Single nonce: nonce_base=0x12345678, num_nonces=1, target=0xFFFFFFFF, message_addr=0x0000, output_addr=0x0100 -> memory word 0x0013 = 0x12345678; found=1, found_nonce=0x12345678; done returns to 1.
2. No hit: num_nonces=4, target=0 -> 4 core_start pulses; found=0; final memory word 0x0013 = nonce_base+3.
3. Hit mid-range: behavioural core returns h0=0x00000010 only for nonce 2 of base 0; target=0x100, num_nonces=8 -> exactly 3 launches; found_nonce=2.
4. Wrap: nonce_base=0xFFFFFFFF, num_nonces=2, target=0 -> patched nonces 0xFFFFFFFF then 0x00000000.
5. Watchdog: core holds core_done=0 forever, TIMEOUT_CYCLES=32 -> timeout=1 within 32 cycles of LAUNCH; state IDLE; mem_we=0.
6. Reset mid-WAIT_DONE -> next cycle done=1, core_start=0, found=0; start during busy ignored; num_nonces=0 -> no memory write.
